game_uart_reporter: RTL and testbench
=====================================

# game_uart_reporter

Transmit-side companion of the game command decoder: it turns game events (round start, score change, round end) into short ASCII messages and drives the byte-level handshake of the shared `uart` core (`transmit`, `tx_byte`, `is_transmitting`). It sits beside the control block in the top level and owns the `uart` transmit port, which is otherwise tied off. Events are coalesced into pending flags, so a slow line never blocks the game and never overflows.

## Interface

- `SCORE_EN`, default 1: when 0, score-change messages are suppressed; START and END messages still go out.
- `clk` in 1: system clock, 100 MHz domain shared with the control block.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: round active, from the control block.
- `over` in 1: round finished, from the control block.
- `score` in 16: four BCD digits, most significant digit in bits [15:12].
- `is_transmitting` in 1: `uart` busy flag; goes high the cycle after `transmit` and stays high until the stop bit is done.
- `transmit` out 1: one-cycle strobe to `uart`.
- `tx_byte` out 8: byte to send; valid while `transmit` is high and held until the next load.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

- Messages:
  - START = "GO\r\n" (4 bytes).
  - SCORE = "S:dddd\r\n" (8 bytes).
  - END = "END:dddd\r\n" (10 bytes).
  - Each `d` is `8'h30 + nibble`; a nibble above 9 is sent as "?" (`8'h3F`).
- Event detection uses registered `prev_start` and `prev_over`:
  - Rising `start`: set `start_pend`, clear `score_pend`, clear `last_score` to 0.
  - Rising `over`: set `over_pend`, clear `score_pend`.
  - `SCORE_EN && start && !over && score != last_score && !over_pend` sets `score_pend`.
- Priority at LOAD: END, then START, then SCORE.
- The chosen pending flag clears in LOAD.
- For SCORE and END, `score` is snapshotted into `snap` and into `last_score` in LOAD, so the digits stay stable for the whole message.
- FSM states:
  - IDLE: wait for any pending flag, then go to LOAD.
  - LOAD: latch the message id, set index = 0, take the snapshot.
  - SEND: drive `tx_byte` = rom(id, index) and `transmit` = 1 for exactly one cycle.
  - GUARD: one cycle; `is_transmitting` is ignored here.
  - DRAIN: wait until `is_transmitting` == 0.
  - NEXT: if index == len-1, go to IDLE; otherwise increment index and go to SEND.
- Events that arrive during a message only set flags. They are served after the current message ends and never preempt it.
- A flag that is set again while already pending is coalesced into one message.
- `over` and `start` rising in the same cycle: both flags are set; END is sent first, then GO.

## Timing

- Reset values: `transmit` = 0, `tx_byte` = 0, `busy` = 0, all flags 0, `last_score` = 0, `prev_*` = 0, state IDLE.
- Reset is asynchronous and aborts any message mid-byte. The `uart` is reset by the same `reset_n`.
- Event latency: event at edge t sets the flag at t+1. From IDLE the FSM goes LOAD at t+2, SEND at t+3, so the first `transmit` is seen at cycle t+3.
- Per-byte overhead: NEXT to SEND is 2 cycles beyond the uart frame time. The uart frame itself dominates (about 10 bit times).
- `tx_byte` changes only in SEND and holds through GUARD, DRAIN and NEXT.
- Exactly one `transmit` pulse per message byte. `transmit` is never high while `is_transmitting` is high.
- Width rules:
  - `index` is 4 bits.
  - Message lengths are 4, 8 and 10 bytes; `index` never exceeds 9.

## Structure

- The `msg_id_t` enum (MSG_GO, MSG_SCORE, MSG_END) and the length constants go into the shared enum package next to `state_type`.
- The FSM state enum is local to the module.
- One sub-module, `uart_msg_rom`: purely combinational. It maps (id, index, snap) to a byte and outputs `last` = (index == len-1).
- The top level instantiates `uart` once and connects this block to its tx side. The control block keeps the rx side.

## Test plan

- Reset, then `start` rising with `score` = 0 -> exactly bytes 47 4F 0D 0A, one `transmit` per byte; `busy` falls after the last DRAIN.
- `score` 0000 -> 0123 while `start` = 1 -> "S:0123\r\n" = 53 3A 30 31 32 33 0D 0A; no resend while `score` stays 0123.
- `score` changes 0001 -> 0002 -> 0003 during one message -> a single follow-up message "S:0003\r\n" (coalesced).
- `score` = 0042, `over` and `start` rise in the same cycle -> "END:0042\r\n" then "GO\r\n"; no SCORE message.
- `score` = 00A5 then `over` -> "END:00?5\r\n".
- `reset_n` low during byte 3 of a SCORE message -> `transmit` and `busy` are 0 immediately. After release, nothing is sent until a new event.

Source files
------------

// File: rtl/game_uart_reporter_pkg.sv
// Shared types for the game UART reporter: message ids, message lengths,
// ASCII constants and the BCD-digit-to-character helper used by the ROM.
// Pure declarations; no logic, no timing.
package game_uart_reporter_pkg;

  // Which canned message is being sent.
  typedef enum logic [1:0] {
    MSG_GO    = 2'd0,
    MSG_SCORE = 2'd1,
    MSG_END   = 2'd2
  } msg_id_t;

  // Message lengths in bytes; the byte index never reaches 10.
  localparam logic [3:0] LEN_GO    = 4'd4;
  localparam logic [3:0] LEN_SCORE = 4'd8;
  localparam logic [3:0] LEN_END   = 4'd10;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_QMARK = 8'h3F;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // A non-decimal nibble is shown as '?' so corrupt scores stay visible.
  function automatic logic [7:0] bcd_char(input logic [3:0] nib);
    if (nib > 4'd9) begin
      bcd_char = CH_QMARK;
    end else begin
      bcd_char = CH_ZERO + {4'h0, nib};
    end
  endfunction

  // Length of a message by id.
  function automatic logic [3:0] msg_len(input msg_id_t id);
    case (id)
      MSG_GO:    msg_len = LEN_GO;
      MSG_SCORE: msg_len = LEN_SCORE;
      MSG_END:   msg_len = LEN_END;
      default:   msg_len = LEN_GO;
    endcase
  endfunction

endpackage

// File: rtl/game_uart_reporter_rom.sv
// Message ROM: maps (message id, byte index, score snapshot) to an ASCII byte.
// Purely combinational, zero latency.
// No handshake; the caller walks the index and uses 'last' to stop.
module uart_msg_rom
  import game_uart_reporter_pkg::*;
(
  input  msg_id_t     i_id,
  input  logic [3:0]  i_index,
  input  logic [15:0] i_snap,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [7:0] w_d3;
  logic [7:0] w_d2;
  logic [7:0] w_d1;
  logic [7:0] w_d0;

  assign w_d3 = bcd_char(i_snap[15:12]);
  assign w_d2 = bcd_char(i_snap[11:8]);
  assign w_d1 = bcd_char(i_snap[7:4]);
  assign w_d0 = bcd_char(i_snap[3:0]);

  assign o_last = (i_index == (msg_len(i_id) - 4'd1));

  // Byte lookup for "GO\r\n", "S:dddd\r\n" and "END:dddd\r\n".
  always_comb begin
    o_byte = 8'h00;
    case (i_id)
      MSG_GO: begin
        case (i_index)
          4'd0:    o_byte = 8'h47;
          4'd1:    o_byte = 8'h4F;
          4'd2:    o_byte = CH_CR;
          4'd3:    o_byte = CH_LF;
          default: o_byte = 8'h00;
        endcase
      end
      MSG_SCORE: begin
        case (i_index)
          4'd0:    o_byte = 8'h53;
          4'd1:    o_byte = CH_COLON;
          4'd2:    o_byte = w_d3;
          4'd3:    o_byte = w_d2;
          4'd4:    o_byte = w_d1;
          4'd5:    o_byte = w_d0;
          4'd6:    o_byte = CH_CR;
          4'd7:    o_byte = CH_LF;
          default: o_byte = 8'h00;
        endcase
      end
      MSG_END: begin
        case (i_index)
          4'd0:    o_byte = 8'h45;
          4'd1:    o_byte = 8'h4E;
          4'd2:    o_byte = 8'h44;
          4'd3:    o_byte = CH_COLON;
          4'd4:    o_byte = w_d3;
          4'd5:    o_byte = w_d2;
          4'd6:    o_byte = w_d1;
          4'd7:    o_byte = w_d0;
          4'd8:    o_byte = CH_CR;
          4'd9:    o_byte = CH_LF;
          default: o_byte = 8'h00;
        endcase
      end
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/game_uart_reporter.sv
// Game event reporter: turns round start / score change / round end into ASCII lines on the uart tx port.
// First transmit three cycles after the event edge; then one byte per uart frame plus a few cycles.
// Never stalls the game: events only set pending flags, repeats coalesce, sending waits on is_transmitting.
module game_uart_reporter
  import game_uart_reporter_pkg::*;
#(
  parameter bit SCORE_EN = 1'b1
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        over,
  input  logic [15:0] score,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_GUARD = 3'd3,
    ST_DRAIN = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_prev_start;
  logic        r_prev_over;
  logic        r_start_pend;
  logic        r_score_pend;
  logic        r_over_pend;
  logic [15:0] r_last_score;
  logic [15:0] r_snap;
  msg_id_t     r_msg_id;
  logic [3:0]  r_index;
  logic [7:0]  r_tx_byte;

  logic        w_start_rise;
  logic        w_over_rise;
  logic        w_score_chg;
  logic        w_any_pend;
  logic        w_load;
  msg_id_t     w_sel_id;
  logic [7:0]  w_rom_byte;
  logic        w_rom_last;

  assign w_start_rise = start & ~r_prev_start;
  assign w_over_rise  = over & ~r_prev_over;
  // Score changes only count inside a live round and not once END is queued.
  assign w_score_chg  = SCORE_EN && start && !over && (score != r_last_score) && !r_over_pend;
  assign w_any_pend   = r_start_pend | r_score_pend | r_over_pend;
  assign w_load       = (r_state == ST_LOAD);

  // END beats GO beats SCORE, so a simultaneous over+start reports the old round first.
  assign w_sel_id = r_over_pend  ? MSG_END :
                    r_start_pend ? MSG_GO  : MSG_SCORE;

  uart_msg_rom u_rom (
    .i_id    (r_msg_id),
    .i_index (r_index),
    .i_snap  (r_snap),
    .o_byte  (w_rom_byte),
    .o_last  (w_rom_last)
  );

  // Edge detectors and pending flags; a fresh edge wins over a same-cycle clear in LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_start <= 1'b0;
      r_prev_over  <= 1'b0;
      r_start_pend <= 1'b0;
      r_over_pend  <= 1'b0;
      r_score_pend <= 1'b0;
    end else begin
      r_prev_start <= start;
      r_prev_over  <= over;

      if (w_start_rise) begin
        r_start_pend <= 1'b1;
      end else if (w_load && (w_sel_id == MSG_GO)) begin
        r_start_pend <= 1'b0;
      end

      if (w_over_rise) begin
        r_over_pend <= 1'b1;
      end else if (w_load && (w_sel_id == MSG_END)) begin
        r_over_pend <= 1'b0;
      end

      // In LOAD last_score is still stale, so the clear must beat the change detector.
      if (w_start_rise || w_over_rise || (w_load && (w_sel_id == MSG_SCORE))) begin
        r_score_pend <= 1'b0;
      end else if (w_score_chg) begin
        r_score_pend <= 1'b1;
      end
    end
  end

  // Score baseline: zeroed by a new round, refreshed whenever digits are snapshotted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_score <= 16'h0000;
    end else if (w_start_rise) begin
      r_last_score <= 16'h0000;
    end else if (w_load && (w_sel_id != MSG_GO)) begin
      r_last_score <= score;
    end
  end

  // Message context: id, byte index, frozen digits and the held output byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_id  <= MSG_GO;
      r_index   <= 4'd0;
      r_snap    <= 16'h0000;
      r_tx_byte <= 8'h00;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_msg_id <= w_sel_id;
          r_index  <= 4'd0;
          if (w_sel_id != MSG_GO) begin
            r_snap <= score;
          end
        end
        ST_SEND: r_tx_byte <= w_rom_byte;
        ST_NEXT: begin
          if (!w_rom_last) begin
            r_index <= r_index + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one byte per SEND, GUARD skips the uart's one-cycle busy lag.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_pend) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SEND;
      ST_SEND:  w_state_nxt = ST_GUARD;
      ST_GUARD: w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!is_transmitting) w_state_nxt = ST_NEXT;
      ST_NEXT:  w_state_nxt = w_rom_last ? ST_IDLE : ST_SEND;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: strobe only in SEND; the byte is live in SEND and held afterwards.
  always_comb begin
    transmit = (r_state == ST_SEND);
    tx_byte  = (r_state == ST_SEND) ? w_rom_byte : r_tx_byte;
    busy     = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_game_uart_reporter.sv
// Directed-plus-random bench for game_uart_reporter with a behavioural uart and message scoreboard.
module tb_game_uart_reporter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        over;
  logic [15:0] score;
  logic        is_transmitting = 1'b0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int frame_left = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  game_uart_reporter #(.SCORE_EN(1'b1)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .over            (over),
    .score           (score),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Behavioural uart: samples mid-cycle, busy for a random frame length.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_transmitting <= 1'b0;
      frame_left = 0;
    end else if (transmit === 1'b1) begin
      check("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
      got_q.push_back(tx_byte);
      frame_left = $urandom_range(3, 10);
      is_transmitting <= 1'b1;
    end else if (frame_left > 0) begin
      frame_left--;
      if (frame_left == 0) is_transmitting <= 1'b0;
    end
  end

  // Reference message builders, straight from the message formats.
  function automatic logic [7:0] dch(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
  endfunction

  task automatic push_digits(input logic [15:0] s);
    exp_q.push_back(dch(s[15:12]));
    exp_q.push_back(dch(s[11:8]));
    exp_q.push_back(dch(s[7:4]));
    exp_q.push_back(dch(s[3:0]));
  endtask

  task automatic push_go();
    exp_q.push_back(8'h47); exp_q.push_back(8'h4F);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic push_score(input logic [15:0] s);
    exp_q.push_back(8'h53); exp_q.push_back(8'h3A);
    push_digits(s);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic push_end(input logic [15:0] s);
    exp_q.push_back(8'h45); exp_q.push_back(8'h4E);
    exp_q.push_back(8'h44); exp_q.push_back(8'h3A);
    push_digits(s);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until the reporter and uart have been quiet for a while.
  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < 5000) begin
      tick(1);
      n++;
      if (busy === 1'b0 && is_transmitting === 1'b0) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle_timeout"}, {31'd0, (n < 5000)}, 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 2000) begin
      tick(1);
      n++;
    end
    check({tag, "_byte_timeout"}, {31'd0, (n < 2000)}, 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic [15:0] s_c;
    int n;

    reset_n = 1'b0; start = 1'b0; over = 1'b0; score = 16'h0000;
    tick(2);
    check("rst_transmit", {31'd0, transmit}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick(3);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Round start with score 0: GO only, first strobe three edges later.
    start = 1'b1;
    push_go();
    n = 0;
    while (transmit !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("go_latency", n, 32'd3);
    wait_idle("go");
    check("go_busy_low", {31'd0, busy}, 32'd0);
    compare("go");

    // Score change inside the round, then no resend while steady.
    score = 16'h0123;
    push_score(16'h0123);
    wait_idle("s0123");
    compare("s0123");
    tick(40);
    check("no_resend", got_q.size(), 32'd0);

    // Random score changes, one message each.
    for (int k = 0; k < 3; k++) begin
      do s_a = rand_bcd(); while (s_a == score);
      score = s_a;
      push_score(s_a);
      wait_idle("srand");
      compare($sformatf("srand%0d", k));
    end

    // Changes during a message coalesce into one follow-up with the latest value.
    score = 16'h0001;
    push_score(16'h0001);
    wait_bytes("coal", 1);
    score = 16'h0002;
    tick(2);
    score = 16'h0003;
    push_score(16'h0003);
    wait_idle("coal");
    compare("coal");

    do s_a = rand_bcd(); while (s_a == score);
    do s_b = rand_bcd(); while (s_b == s_a);
    do s_c = rand_bcd(); while (s_c == s_b || s_c == s_a);
    score = s_a;
    push_score(s_a);
    wait_bytes("rcoal", 1);
    score = s_b;
    tick(3);
    score = s_c;
    push_score(s_c);
    wait_idle("rcoal");
    compare("rcoal");

    // over and start rising together: END first, then GO, no SCORE.
    start = 1'b0;
    score = 16'h0042;
    tick(5);
    start = 1'b1;
    over = 1'b1;
    push_end(16'h0042);
    push_go();
    wait_idle("endgo");
    compare("endgo");
    tick(30);
    check("endgo_no_score", got_q.size(), 32'd0);

    // Non-decimal digit shows as '?'.
    start = 1'b0;
    over = 1'b0;
    score = 16'h00A5;
    tick(3);
    over = 1'b1;
    push_end(16'h00A5);
    wait_idle("endq");
    compare("endq");

    for (int k = 0; k < 2; k++) begin
      over = 1'b0;
      score = 16'($urandom_range(0, 65535));
      tick(3);
      over = 1'b1;
      push_end(score);
      wait_idle("endr");
      compare($sformatf("endr%0d", k));
    end

    // Reset during byte 3 of a SCORE message.
    over = 1'b0;
    start = 1'b0;
    score = 16'h0000;
    tick(3);
    start = 1'b1;
    push_go();
    wait_idle("pre_rst");
    compare("pre_rst");
    do s_a = rand_bcd(); while (s_a == 16'h0000);
    score = s_a;
    push_score(s_a);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    wait_bytes("rst_mid", 3);
    #2;
    reset_n = 1'b0;
    start = 1'b0;
    over = 1'b0;
    #1;
    check("rst_mid_transmit", {31'd0, transmit}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_tx_byte", {24'd0, tx_byte}, 32'd0);
    compare("rst_trunc");
    tick(2);
    @(negedge clk) reset_n = 1'b1;
    tick(50);
    check("post_rst_silent", got_q.size(), 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // A new event after reset is served normally.
    score = 16'h0000;
    start = 1'b1;
    push_go();
    wait_idle("post_rst_go");
    compare("post_rst_go");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
